hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Parametrised data-hazard controller for the 5-stage pipeline.
//  - Forwarding: per-operand bypass selection from both EX/MEM and MEM/WB, with EX/MEM taking priority.
//  - Load-use: detection plus a multi-cycle stall FSM, for loads whose data returns LOAD_LAT cycles late.
//  - Counters: saturating stall-cycle and forward-event performance counters.
//  - Placement: sits beside the ID/EX register; drives the EX operand muxes, PC/IF-ID write enables and the ID/EX bubble.
// PARAMETERS
//  REG_AW    5   register-address width (x0 = all zeros, never forwarded)
//  NUM_SRC   2   source operands per instruction (generalises rs1/rs2)
//  LOAD_LAT  1   stall cycles a load-use hazard costs (>=1)
//  CNT_W     32  width of each performance counter
// PORTS
//  clk           in   1                clock
//  rst           in   1                synchronous, active-high reset
//  id_src        in   NUM_SRC*REG_AW   source regs of the instr in ID (operand k at [k*REG_AW +: REG_AW])
//  id_src_used   in   NUM_SRC          bit k=1: the ID instr reads operand k
//  ex_src        in   NUM_SRC*REG_AW   source regs of the instr in EX (from ID/EX)
//  ex_rd         in   REG_AW           dest of the instr in EX
//  ex_memread    in   1                instr in EX is a load
//  mem_rd        in   REG_AW           EX/MEM dest
//  mem_regwrite  in   1                EX/MEM writes regfile
//  wb_rd         in   REG_AW           MEM/WB dest
//  wb_regwrite   in   1                MEM/WB writes regfile
//  flush         in   1                branch/jump redirect this cycle
//  fwd_sel       out  2*NUM_SRC        per operand: 00 regfile, 01 MEM/WB, 10 EX/MEM
//  pc_hold       out  1                hold PC and IF/ID
//  idex_bubble   out  1                zero control bits entering ID/EX
//  stall_cnt     out  CNT_W            cycles with pc_hold=1 (saturating)
//  fwd_cnt       out  CNT_W            cycles with any fwd_sel!=00 (saturating)
// BEHAVIOUR
//  Forwarding (combinational, same cycle), per operand k:
//   - 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_src[k];
//   - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_src[k];
//   - else 00.
//  Load-use hazard: hz = ex_memread && ex_rd!=0 && OR_k(id_src_used[k] && id_src[k]==ex_rd).
//  FSM:
//   - States IDLE, WAIT; remaining-cycle counter rem, width clog2(LOAD_LAT+1).
//   - IDLE:
//     - hz && !flush: pc_hold=1, idex_bubble=1.
//     - If LOAD_LAT>1: go to WAIT with rem=LOAD_LAT-1; otherwise stay in IDLE.
//   - WAIT: pc_hold=1, idex_bubble=1, rem decrements each cycle; when rem reaches 1 it returns to IDLE on the next edge.
//   - While in WAIT, hz is ignored (the load has left EX). A total of exactly LOAD_LAT stall cycles occurs per hazard.
//  flush:
//   - Overrides all stalls: pc_hold=0 and idex_bubble=1 that cycle.
//   - FSM goes to IDLE and rem is cleared, including mid-WAIT.
//  Reset (rst=1 at edge):
//   - state=IDLE, rem=0, stall_cnt=0, fwd_cnt=0.
//   - While rst is high: fwd_sel=0, pc_hold=0, idex_bubble=0.
//  Counters:
//   - Each counter increments by 1 on an edge where its condition holds and rst=0.
//   - Each holds at all-ones (no wrap).
//   - A cycle with several operands forwarding counts once.
//  Simultaneous events:
//   - hz and flush in the same cycle: flush wins, no stall, no count.
//   - mem_rd==wb_rd: EX/MEM wins.
//   - An operand with id_src_used=0 never causes a stall.
// STRUCTURE
//  - Shared package hazard_pkg: FWD_RF/FWD_WB/FWD_MEM 2-bit encodings, and the hz_state_t enum {HZ_IDLE, HZ_WAIT}.
//  - Sub-module fwd_operand_sel: one operand's comparator/priority logic, instanced NUM_SRC times via generate.
//  - The FSM and counters live in the top module.
// TESTING
//  1. mem: rd=5, regwrite=1; wb: rd=5, regwrite=1; ex_src[0]=5 -> fwd_sel[1:0]=10; with mem_regwrite=0 -> 01.
//  2. mem_rd=0, mem_regwrite=1, ex_src[0]=0 -> fwd_sel[1:0]=00; fwd_cnt unchanged.
//  3. LOAD_LAT=1; ex_memread=1, ex_rd=7, id_src[1]=7, id_src_used=2'b10 -> pc_hold=1 for exactly 1 cycle; stall_cnt +1.
//     With id_src_used=2'b01 -> no stall.
//  4. LOAD_LAT=3, same hazard -> pc_hold=idex_bubble=1 for 3 consecutive cycles, then 0; stall_cnt=3.
//  5. LOAD_LAT=3, flush=1 on the 2nd stall cycle -> pc_hold=0 that cycle, FSM IDLE next cycle; stall_cnt=1.
//  6. CNT_W=4, forward 20 consecutive cycles -> fwd_cnt saturates at 15. rst mid-WAIT -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    // Operand-mux select encodings driven into the EX stage.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Load-use stall FSM states.
    typedef enum logic {
        HZ_IDLE,
        HZ_WAIT
    } hz_state_t;

endpackage

// File: rtl/fwd_operand_sel.sv
// Bypass selection for a single EX source operand; EX/MEM beats MEM/WB.
module fwd_operand_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] srcReg,
    input  logic [REG_AW-1:0] memRd,
    input  logic              memRegwrite,
    input  logic [REG_AW-1:0] wbRd,
    input  logic              wbRegwrite,
    output logic [1:0]        sel
);

    // Priority compare; x0 is hard-wired zero and never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (memRegwrite && (memRd != '0) && (memRd == srcReg)) begin
            sel = FWD_MEM;
        end else if (wbRegwrite && (wbRd != '0) && (wbRd == srcReg)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Data-hazard controller: operand forwarding, multi-cycle load-use stall
// and saturating stall/forward performance counters.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_memread,
    input  logic [REG_AW-1:0]           mem_rd,
    input  logic                        mem_regwrite,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic                        wb_regwrite,
    input  logic                        flush,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        pc_hold,
    output logic                        idex_bubble,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            fwd_cnt
);

    localparam int REM_W = $clog2(LOAD_LAT + 1);

    hz_state_t          state;
    logic [REM_W-1:0]   rem;
    logic [2*NUM_SRC-1:0] fwdRaw;
    logic               loadUse;
    logic               hz;
    logic               stallReq;

    for (genvar k = 0; k < NUM_SRC; k++) begin : gSel
        fwd_operand_sel #(
            .REG_AW(REG_AW)
        ) uSel (
            .srcReg      (ex_src[k*REG_AW +: REG_AW]),
            .memRd       (mem_rd),
            .memRegwrite (mem_regwrite),
            .wbRd        (wb_rd),
            .wbRegwrite  (wb_regwrite),
            .sel         (fwdRaw[2*k +: 2])
        );
    end

    // Load-use detection against every operand the ID instruction actually reads.
    always_comb begin
        loadUse = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] == ex_rd)) begin
                loadUse = 1'b1;
            end
        end
        hz = ex_memread && (ex_rd != '0) && loadUse;
    end

    // Pipeline control: WAIT stalls unconditionally, flush overrides any stall.
    always_comb begin
        stallReq    = (state == HZ_WAIT) || ((state == HZ_IDLE) && hz);
        fwd_sel     = rst ? '0 : fwdRaw;
        pc_hold     = !rst && !flush && stallReq;
        idex_bubble = !rst && (flush || stallReq);
    end

    // Stall FSM: the IDLE cycle that detects the hazard is the first stall cycle,
    // so WAIT only has to cover the remaining LOAD_LAT-1 cycles.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= HZ_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    if (hz && (LOAD_LAT > 1)) begin
                        state <= HZ_WAIT;
                        rem   <= REM_W'(LOAD_LAT - 1);
                    end
                end
                HZ_WAIT: begin
                    if (rem <= REM_W'(1)) begin
                        state <= HZ_IDLE;
                        rem   <= '0;
                    end else begin
                        rem <= rem - REM_W'(1);
                    end
                end
                default: begin
                    state <= HZ_IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (pc_hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((|fwd_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

endmodule
